rf_wb_scheduler: RTL and testbench
==================================

// Module: rf_wb_scheduler
// PURPOSE
//  Issue/write-back scheduler for the 8-entry, x0-hardwired register file. Scoreboards
//  destination registers between issue and write-back; blocks RAW/WAW hazards at issue.
//  Round-robin arbitrates the ALU and load-unit write-back requesters onto the single
//  register-file write port through one output register stage. Sits between decode and regfile.
// PARAMETERS
//  WIDTH    `WIDTH (8)  data width of write-back path, equal to the register-file width
//  NREG     8           register count; address width is 3 bits
//  STALL_W  8           width of the saturating stall counter
// PORTS
//  clk          in   1      clock, all state on rising edge
//  rst_n        in   1      asynchronous active-low reset
//  iss_valid    in   1      decode presents an instruction
//  iss_rs1      in   3      source register 1
//  iss_rs2      in   3      source register 2
//  iss_rd       in   3      destination register; 0 = no destination
//  iss_ready    out  1      instruction accepted this cycle when iss_valid & iss_ready
//  alu_valid    in   1      ALU write-back request (requester 0)
//  alu_rd       in   3      ALU destination
//  alu_data     in   WIDTH  ALU result
//  alu_ready    out  1      ALU request granted this cycle
//  mem_valid    in   1      load-unit write-back request (requester 1)
//  mem_rd       in   3      load destination
//  mem_data     in   WIDTH  load data
//  mem_ready    out  1      load request granted this cycle
//  rf_we        out  1      register-file write enable (registered)
//  rf_waddr     out  3      register-file write address (registered)
//  rf_wdata     out  WIDTH  register-file write data (registered)
//  stall_cnt    out  STALL_W  saturating count of cycles with iss_valid & !iss_ready
//  wb_err       out  1      sticky: write-back granted to a register that is not pending
// BEHAVIOUR
//  Reset: pending[7:0]=0; rf_we=0, rf_waddr=0, rf_wdata=0; stall_cnt=0; wb_err=0;
//   last_grant=1, so the ALU wins the first contention. Reset mid-transfer drops the staged write.
//  Scoreboard: iss_ready = !(pending[rs1] | pending[rs2] | pending[rd]), where pending[0] is always 0.
//   Computed from registered pending only, with no combinational path from write-back inputs.
//   Accepted issue with rd!=0 sets pending[rd] at the clock edge. rd=0 sets nothing.
//  Arbitration: only one of alu_valid/mem_valid high -> grant it. Both high -> grant the requester
//   that is not last_grant. last_grant updates on every grant. No grant -> both ready=0.
//   ready is combinational from valid and last_grant. Requesters hold rd/data until granted.
//  Output stage: granted request registers into rf_we/rf_waddr/rf_wdata the next cycle.
//   Latency from grant to rf_we is 1 cycle. rf_we deasserts when there is no grant. Granted rd=0
//   produces rf_we=0 and no scoreboard change. The stage accepts a grant every cycle with no backpressure.
//  Clear: in the cycle rf_we=1, pending[rf_waddr] clears at that edge, when the regfile writes.
//   A dependent instruction can issue the following cycle and reads the new value.
//  Same-edge set/clear on one register cannot occur: rd pending blocks issue. The set/clear
//   logic still gives set priority.
//  wb_err sets when a grant carries rd!=0 and pending[rd]=0. It clears only on reset.
//  stall_cnt increments on iss_valid & !iss_ready and saturates at 2^STALL_W-1. It does not wrap.
// STRUCTURE
//  Shared package/include: WIDTH macro default, REG_AW=3, NREG=8, and requester ids
//   REQ_ALU=0 and REQ_MEM=1.
//  One natural sub-module, rr_arb2: two-requester round-robin arbiter with last_grant state.
//   Scoreboard, output stage and counter stay inline.
// TESTING
//  1. Issue rd=3. Next cycle issue rs1=3 -> iss_ready=0 until the cycle after rf_we with waddr=3.
//   Then ready=1.
//  2. alu and mem both valid, rd=1 and rd=2, both pending -> ALU granted first, mem next cycle.
//   rf_we for waddr 1 then 2 in consecutive cycles.
//  3. Continuous contention for 4 cycles -> grants alternate ALU, MEM, ALU, MEM.
//  4. Write-back with rd=0, data=8'hFF -> rf_we stays 0, pending unchanged, wb_err=0.
//   Write-back to a non-pending reg 5 -> wb_err=1 and stays 1.
//  5. Hold a hazard for 300 cycles -> stall_cnt=255 (saturated).
//   Assert rst_n=0 mid-test -> all outputs 0 and pending cleared asynchronously.
//  6. Issue rd=0 with rs1=rs2=0 -> iss_ready=1 and no pending bit set. Back-to-back issues
//   to distinct rd 1..7 -> all accepted, pending=8'hFE.

Source files
------------

// File: rtl/rf_wb_scheduler_pkg.sv
// Shared constants and types for the issue/write-back scheduler.
// Address width, register count, requester ids and the staged write-back record.
`ifndef WIDTH
`define WIDTH 8
`endif

package rf_wb_scheduler_pkg;

    localparam int WIDTH   = `WIDTH;
    localparam int REG_AW  = 3;
    localparam int NREG    = 8;
    localparam int STALL_W = 8;

    // Requester ids double as bit positions in the arbiter request/grant vectors
    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [WIDTH-1:0]  wb_data_t;

    typedef struct packed {
        logic      we;
        reg_addr_t addr;
        wb_data_t  data;
    } wb_t;

    function automatic logic [NREG-1:0] reg_onehot(input reg_addr_t a);
        logic [NREG-1:0] r;
        r    = '0;
        r[a] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/rf_wb_scheduler_if.sv
// Decode, write-back requester and register-file write port bundle.
// master = decode/execution side, slave = the scheduler.
interface rf_wb_scheduler_if;
    import rf_wb_scheduler_pkg::*;

    logic                iss_valid;
    reg_addr_t           iss_rs1;
    reg_addr_t           iss_rs2;
    reg_addr_t           iss_rd;
    logic                iss_ready;

    logic                alu_valid;
    reg_addr_t           alu_rd;
    wb_data_t            alu_data;
    logic                alu_ready;

    logic                mem_valid;
    reg_addr_t           mem_rd;
    wb_data_t            mem_data;
    logic                mem_ready;

    logic                rf_we;
    reg_addr_t           rf_waddr;
    wb_data_t            rf_wdata;

    logic [STALL_W-1:0]  stall_cnt;
    logic                wb_err;

    modport master (
        output iss_valid, iss_rs1, iss_rs2, iss_rd,
        input  iss_ready,
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        input  rf_we, rf_waddr, rf_wdata, stall_cnt, wb_err
    );

    modport slave (
        input  iss_valid, iss_rs1, iss_rs2, iss_rd,
        output iss_ready,
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        output rf_we, rf_waddr, rf_wdata, stall_cnt, wb_err
    );

endinterface

// File: rtl/rf_wb_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter; on contention grants the requester not granted last.
// Latency: grant is combinational from req; last_grant updates at the edge after any grant.
// Backpressure: a requester not granted sees gnt=0 and must hold its request.
module rr_arb2
    import rf_wb_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // 1 = the load unit won last, so the ALU wins the first contention after reset
    logic last_grant;

    always_comb begin
        gnt = '0;
        if (req[REQ_ALU] && req[REQ_MEM]) begin
            if (last_grant) begin
                gnt[REQ_ALU] = 1'b1;
            end else begin
                gnt[REQ_MEM] = 1'b1;
            end
        end else begin
            gnt = req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (|gnt) begin
            last_grant <= gnt[REQ_MEM];
        end
    end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Issue/write-back scheduler: scoreboards destinations, blocks RAW/WAW, arbitrates write-back.
// Latency: grant to rf_we is 1 cycle; pending clears at the edge ending the rf_we cycle.
// Backpressure: issue stalls on a pending register; write-back losers hold until granted.
module rf_wb_scheduler
    import rf_wb_scheduler_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    rf_wb_scheduler_if.slave bus
);

    logic [NREG-1:0]    pending;
    logic [NREG-1:0]    pending_nxt;
    logic [NREG-1:0]    set_mask;
    logic [NREG-1:0]    clr_mask;
    logic               iss_ready;
    logic               iss_fire;
    logic [1:0]         wb_req;
    logic [1:0]         wb_gnt;
    logic               gnt_any;
    wb_t                gnt_wb;
    wb_t                wb_q;
    logic               wb_err_q;
    logic [STALL_W-1:0] stall_q;

    // Registered scoreboard only, so write-back inputs never reach iss_ready
    assign iss_ready = ~(pending[bus.iss_rs1] | pending[bus.iss_rs2] | pending[bus.iss_rd]);
    assign iss_fire  = bus.iss_valid & iss_ready;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (iss_fire && (bus.iss_rd != '0)) begin
            set_mask = reg_onehot(bus.iss_rd);
        end
        if (wb_q.we) begin
            clr_mask = reg_onehot(wb_q.addr);
        end
        // Set wins over clear; x0 is never tracked
        pending_nxt    = (pending & ~clr_mask) | set_mask;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign wb_req[REQ_ALU] = bus.alu_valid;
    assign wb_req[REQ_MEM] = bus.mem_valid;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (wb_req),
        .gnt   (wb_gnt)
    );

    assign bus.alu_ready = wb_gnt[REQ_ALU];
    assign bus.mem_ready = wb_gnt[REQ_MEM];
    assign gnt_any       = |wb_gnt;

    always_comb begin
        gnt_wb.we   = 1'b0;
        gnt_wb.addr = bus.alu_rd;
        gnt_wb.data = bus.alu_data;
        if (wb_gnt[REQ_MEM]) begin
            gnt_wb.addr = bus.mem_rd;
            gnt_wb.data = bus.mem_data;
        end
        // A granted write to x0 is consumed but never reaches the register file
        gnt_wb.we = gnt_any && (gnt_wb.addr != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q <= '0;
        end else begin
            wb_q.we <= gnt_wb.we;
            if (gnt_wb.we) begin
                wb_q.addr <= gnt_wb.addr;
                wb_q.data <= gnt_wb.data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_err_q <= 1'b0;
        end else if (gnt_wb.we && !pending[gnt_wb.addr]) begin
            wb_err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (bus.iss_valid && !iss_ready && (stall_q != '1)) begin
            stall_q <= stall_q + STALL_W'(1);
        end
    end

    assign bus.iss_ready = iss_ready;
    assign bus.rf_we     = wb_q.we;
    assign bus.rf_waddr  = wb_q.addr;
    assign bus.rf_wdata  = wb_q.data;
    assign bus.wb_err    = wb_err_q;
    assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Table-driven bench for rf_wb_scheduler with a write-back scoreboard queue,
// plus hand sequences for stall saturation and asynchronous reset.
module tb_rf_wb_scheduler;
    import rf_wb_scheduler_pkg::*;

    logic clk;
    logic rst_n;

    rf_wb_scheduler_if bus ();

    rf_wb_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [2:0] rs1, rs2, rd;
        logic       av;
        logic [2:0] ard;
        logic [7:0] ad;
        logic       mv;
        logic [2:0] mrd;
        logic [7:0] md;
        logic       e_ir, e_ar, e_mr, e_err;
    } vec_t;

    typedef struct {
        logic       we;
        logic [2:0] addr;
        logic [7:0] data;
    } exp_wb_t;

    vec_t    tbl[64];
    int      ntbl;
    exp_wb_t exp_q[$];
    int      checks;
    int      errors;
    int      row_id;
    int      exp_stall;

    function automatic vec_t mk(input logic iv, input logic [2:0] rs1, input logic [2:0] rs2,
                                input logic [2:0] rd, input logic av, input logic [2:0] ard,
                                input logic [7:0] ad, input logic mv, input logic [2:0] mrd,
                                input logic [7:0] md, input logic e_ir, input logic e_ar,
                                input logic e_mr, input logic e_err);
        vec_t v;
        v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.av = av; v.ard = ard; v.ad = ad;
        v.mv = mv; v.mrd = mrd; v.md = md;
        v.e_ir = e_ir; v.e_ar = e_ar; v.e_mr = e_mr; v.e_err = e_err;
        return v;
    endfunction

    task automatic add(input vec_t v);
        tbl[ntbl] = v;
        ntbl++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row_id, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.iss_valid = v.iv;
        bus.iss_rs1   = v.rs1;
        bus.iss_rs2   = v.rs2;
        bus.iss_rd    = v.rd;
        bus.alu_valid = v.av;
        bus.alu_rd    = v.ard;
        bus.alu_data  = v.ad;
        bus.mem_valid = v.mv;
        bus.mem_rd    = v.mrd;
        bus.mem_data  = v.md;
    endtask

    // Drive one cycle of stimulus, check at the falling edge, then queue the expected write
    task automatic apply_row(input vec_t v);
        exp_wb_t e;
        exp_wb_t n;
        drive(v);
        @(negedge clk);
        chk("iss_ready", 32'(bus.iss_ready), 32'(v.e_ir));
        chk("alu_ready", 32'(bus.alu_ready), 32'(v.e_ar));
        chk("mem_ready", 32'(bus.mem_ready), 32'(v.e_mr));
        chk("wb_err", 32'(bus.wb_err), 32'(v.e_err));
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(exp_stall));
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard row %0d: got empty queue expected one entry", row_id);
        end else begin
            e = exp_q.pop_front();
            chk("rf_we", 32'(bus.rf_we), 32'(e.we));
            if (e.we) begin
                chk("rf_waddr", 32'(bus.rf_waddr), 32'(e.addr));
                chk("rf_wdata", 32'(bus.rf_wdata), 32'(e.data));
            end
        end
        n.we = 1'b0; n.addr = 3'd0; n.data = 8'h00;
        if (v.e_ar) begin
            n.we = (v.ard != 3'd0); n.addr = v.ard; n.data = v.ad;
        end else if (v.e_mr) begin
            n.we = (v.mrd != 3'd0); n.addr = v.mrd; n.data = v.md;
        end
        exp_q.push_back(n);
        if (v.iv && !v.e_ir && exp_stall < 255) exp_stall++;
        @(posedge clk);
        #1;
        row_id++;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t idle;
        vec_t v;
        exp_wb_t r0;
        checks = 0; errors = 0; row_id = 0; ntbl = 0; exp_stall = 0;
        idle = mk(0,0,0,0, 0,0,8'h00, 0,0,8'h00, 1,0,0,0);

        // Issue rd=0 then fill rd 1..7, then probe each as a RAW/WAW hazard
        add(mk(1,0,0,0, 0,0,8'h00, 0,0,8'h00, 1,0,0,0));
        for (int k = 1; k < 8; k++) add(mk(1,0,0,3'(k), 0,0,8'h00, 0,0,8'h00, 1,0,0,0));
        for (int k = 1; k < 8; k++) begin
            if (k % 2 == 1) add(mk(1,3'(k),0,0, 0,0,8'h00, 0,0,8'h00, 0,0,0,0));
            else            add(mk(1,0,3'(k),0, 0,0,8'h00, 0,0,8'h00, 0,0,0,0));
        end
        add(mk(1,0,0,4, 0,0,8'h00, 0,0,8'h00, 0,0,0,0));
        add(mk(1,0,0,0, 0,0,8'h00, 0,0,8'h00, 1,0,0,0));
        // Simultaneous ALU rd=1 / MEM rd=2: ALU first, MEM next
        add(mk(0,0,0,0, 1,1,8'h11, 1,2,8'h22, 1,1,0,0));
        add(mk(0,0,0,0, 0,0,8'h00, 1,2,8'h22, 1,0,1,0));
        add(mk(1,1,0,0, 0,0,8'h00, 0,0,8'h00, 1,0,0,0));
        // rs1=3 blocked through the rf_we cycle, free the cycle after
        add(mk(1,3,0,0, 1,3,8'h33, 0,0,8'h00, 0,1,0,0));
        add(mk(1,3,0,0, 0,0,8'h00, 0,0,8'h00, 0,0,0,0));
        add(mk(1,3,0,1, 0,0,8'h00, 0,0,8'h00, 1,0,0,0));
        add(mk(1,0,0,2, 0,0,8'h00, 1,4,8'h44, 1,0,1,0));
        // Four cycles of contention: ALU, MEM, ALU, MEM
        add(mk(0,0,0,0, 1,5,8'h55, 1,6,8'h66, 1,1,0,0));
        add(mk(0,0,0,0, 1,7,8'h77, 1,6,8'h66, 1,0,1,0));
        add(mk(0,0,0,0, 1,7,8'h77, 1,1,8'h01, 1,1,0,0));
        add(mk(0,0,0,0, 1,2,8'h02, 1,1,8'h01, 1,0,1,0));
        add(mk(0,0,0,0, 1,2,8'h02, 0,0,8'h00, 1,1,0,0));
        // rd=0 write-back, then write-back to non-pending reg 5
        add(mk(0,0,0,0, 1,0,8'hFF, 0,0,8'h00, 1,1,0,0));
        add(mk(0,0,0,0, 0,0,8'h00, 1,5,8'h55, 1,0,1,0));
        add(mk(0,0,0,0, 0,0,8'h00, 0,0,8'h00, 1,0,0,1));
        add(mk(0,0,0,0, 0,0,8'h00, 0,0,8'h00, 1,0,0,1));

        rst_n = 1'b0;
        drive(idle);
        #12;
        chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("rst_rf_waddr", 32'(bus.rf_waddr), 32'd0);
        chk("rst_rf_wdata", 32'(bus.rf_wdata), 32'd0);
        chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("rst_wb_err", 32'(bus.wb_err), 32'd0);
        chk("rst_iss_ready", 32'(bus.iss_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        r0.we = 1'b0; r0.addr = 3'd0; r0.data = 8'h00;
        exp_q.push_back(r0);

        for (int i = 0; i < ntbl; i++) apply_row(tbl[i]);

        // Hold a RAW hazard long enough to saturate the stall counter
        apply_row(mk(1,0,0,6, 0,0,8'h00, 0,0,8'h00, 1,0,0,1));
        v = mk(1,6,0,0, 0,0,8'h00, 0,0,8'h00, 0,0,0,1);
        for (int i = 0; i < 300; i++) apply_row(v);
        @(negedge clk);
        chk("stall_sat", 32'(bus.stall_cnt), 32'd255);
        chk("stall_iss_ready", 32'(bus.iss_ready), 32'd0);

        // Stage a write to reg 6, then reset mid-transfer
        bus.iss_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 3'd6; bus.alu_data = 8'h66;
        @(posedge clk);
        #1;
        chk("staged_rf_we", 32'(bus.rf_we), 32'd1);
        chk("staged_rf_waddr", 32'(bus.rf_waddr), 32'd6);
        bus.alu_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        bus.iss_valid = 1'b1; bus.iss_rs1 = 3'd6;
        #1;
        chk("arst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("arst_rf_waddr", 32'(bus.rf_waddr), 32'd0);
        chk("arst_rf_wdata", 32'(bus.rf_wdata), 32'd0);
        chk("arst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        chk("arst_wb_err", 32'(bus.wb_err), 32'd0);
        chk("arst_pending_clr", 32'(bus.iss_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.iss_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 3'd1;
        bus.mem_valid = 1'b1; bus.mem_rd = 3'd2;
        #1;
        chk("post_rst_alu_first", 32'(bus.alu_ready), 32'd1);
        chk("post_rst_mem_wait", 32'(bus.mem_ready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
